// File: rtl/cpu_wb_port_arbiter.sv
// Purpose: shares the register-file write port between WB (priority) and a small queue of MDU results.
// Latency: WB writes go through combinationally; a queued MDU result is written 1 cycle after push at the earliest.
// Backpressure: mdu_ready drops when the queue is full; stall_req_wb freezes WB when a queued result starves.
module cpu_wb_port_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWrite_wb,
  input  logic [4:0]  RegWriteAddr_wb,
  input  logic [31:0] RegWriteData_wb,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_addr,
  input  logic [31:0] mdu_data,
  output logic        mdu_ready,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        stall_req_wb,
  output logic [31:0] pending_mask
);

  localparam int PTR_W = (DEPTH > 2) ? 2 : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);

  // Queue storage; q_vld is cleared both on pop and on a WAW kill, so it marks live results only.
  logic [4:0]       q_addr [DEPTH];
  logic [31:0]      q_data [DEPTH];
  logic [DEPTH-1:0] q_vld;

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [OCC_W-1:0] occ;
  logic [3:0]       starve_cnt;
  logic [3:0]       starve_nxt;
  logic             stall_q;

  logic        pw;
  logic        q_empty;
  logic        q_full;
  logic        head_vld;
  logic        pop;
  logic        head_wr;
  logic        push;
  logic        any_vld;
  logic [31:0] pend;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A WB write to $0 never reaches the register file, so it does not claim the port.
  assign pw       = RegWrite_wb && (RegWriteAddr_wb != 5'd0);
  assign q_empty  = (occ == '0);
  assign q_full   = (occ == OCC_W'(DEPTH));
  assign head_vld = q_vld[rd_ptr];
  assign any_vld  = |q_vld;

  // The head leaves whenever WB leaves the port idle; a killed head leaves without a write.
  assign pop      = !pw && !q_empty;
  assign head_wr  = pop && head_vld;

  // MDU results for $0 are acknowledged but dropped.
  assign push     = mdu_valid && mdu_ready && (mdu_addr != 5'd0);

  assign mdu_ready    = !rst && !q_full;
  assign stall_req_wb = !rst && stall_q;
  assign pending_mask = rst ? 32'd0 : pend;

  // Busy mask: one bit per destination register still holding a live queued result.
  always_comb begin
    pend = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q_vld[i]) pend[q_addr[i]] = 1'b1;
    end
  end

  // Write-port mux: WB first, then a live queue head, otherwise drive zeros.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = 32'd0;
    if (!rst) begin
      if (pw) begin
        rf_we    = 1'b1;
        rf_waddr = RegWriteAddr_wb;
        rf_wdata = RegWriteData_wb;
      end else if (head_wr) begin
        rf_we    = 1'b1;
        rf_waddr = q_addr[rd_ptr];
        rf_wdata = q_data[rd_ptr];
      end
    end
  end

  // Starvation count: cycles a live result sat behind WB; cleared once the queue drains or the head lands.
  always_comb begin
    starve_nxt = starve_cnt;
    if (q_empty || head_wr) begin
      starve_nxt = 4'd0;
    end else if (pw && any_vld && (starve_cnt != 4'(STARVE_LIMIT))) begin
      starve_nxt = starve_cnt + 4'd1;
    end
  end

  // Payload registers need no reset: they are only observed through q_vld.
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= mdu_addr;
      q_data[wr_ptr] <= mdu_data;
    end
  end

  // Queue control, WAW kill and starvation state.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_vld      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      occ        <= '0;
      starve_cnt <= 4'd0;
      stall_q    <= 1'b0;
    end else begin
      // A younger WB write to the same register makes the queued result obsolete.
      for (int i = 0; i < DEPTH; i++) begin
        if (pw && q_vld[i] && (q_addr[i] == RegWriteAddr_wb)) q_vld[i] <= 1'b0;
      end
      if (pop) begin
        q_vld[rd_ptr] <= 1'b0;
        rd_ptr        <= ptr_inc(rd_ptr);
      end
      // The push slot is never occupied, so it cannot collide with a kill or a pop above.
      if (push) begin
        q_vld[wr_ptr] <= 1'b1;
        wr_ptr        <= ptr_inc(wr_ptr);
      end
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
      starve_cnt <= starve_nxt;
      stall_q    <= (starve_nxt == 4'(STARVE_LIMIT));
    end
  end

endmodule

// File: tb/tb_cpu_wb_port_arbiter.sv
// Bench for cpu_wb_port_arbiter: directed vector table followed by random traffic against a queue model.
module tb_cpu_wb_port_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWrite_wb;
  logic [4:0]  RegWriteAddr_wb;
  logic [31:0] RegWriteData_wb;
  logic        mdu_valid;
  logic [4:0]  mdu_addr;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        stall_req_wb;
  logic [31:0] pending_mask;

  always #5 clk = ~clk;

  cpu_wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk             (clk),
    .rst             (rst),
    .RegWrite_wb     (RegWrite_wb),
    .RegWriteAddr_wb (RegWriteAddr_wb),
    .RegWriteData_wb (RegWriteData_wb),
    .mdu_valid       (mdu_valid),
    .mdu_addr        (mdu_addr),
    .mdu_data        (mdu_data),
    .mdu_ready       (mdu_ready),
    .rf_we           (rf_we),
    .rf_waddr        (rf_waddr),
    .rf_wdata        (rf_wdata),
    .stall_req_wb    (stall_req_wb),
    .pending_mask    (pending_mask)
  );

  typedef struct packed {
    logic        r;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        mv;
    logic [4:0]  ma;
    logic [31:0] md;
    logic        e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic        e_rdy;
    logic        e_stall;
    logic [31:0] e_mask;
  } vec_t;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
    logic        live;
  } ent_t;

  vec_t tbl[$];
  ent_t mq[$];
  int   m_starve;
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic vec_t mk(input logic r, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic mv, input logic [4:0] ma, input logic [31:0] md,
                              input logic e_we, input logic [4:0] e_wa, input logic [31:0] e_wd,
                              input logic e_rdy, input logic e_stall, input logic [31:0] e_mask);
    vec_t v;
    v.r = r; v.we = we; v.wa = wa; v.wd = wd; v.mv = mv; v.ma = ma; v.md = md;
    v.e_we = e_we; v.e_wa = e_wa; v.e_wd = e_wd; v.e_rdy = e_rdy; v.e_stall = e_stall; v.e_mask = e_mask;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md);
    rst = r; RegWrite_wb = we; RegWriteAddr_wb = wa; RegWriteData_wb = wd;
    mdu_valid = mv; mdu_addr = ma; mdu_data = md;
  endtask

  // Reference: expected outputs from the queue contents and the current inputs.
  task automatic model_out(output logic e_we, output logic [4:0] e_wa, output logic [31:0] e_wd,
                           output logic e_rdy, output logic e_stall, output logic [31:0] e_mask);
    logic pw;
    pw = RegWrite_wb && (RegWriteAddr_wb != 5'd0);
    e_we = 1'b0; e_wa = 5'd0; e_wd = 32'd0; e_rdy = 1'b0; e_stall = 1'b0; e_mask = 32'd0;
    if (!rst) begin
      e_rdy   = (mq.size() < DEPTH);
      e_stall = (m_starve == LIMIT);
      foreach (mq[i]) if (mq[i].live) e_mask = e_mask | (32'd1 << mq[i].a);
      if (pw) begin
        e_we = 1'b1; e_wa = RegWriteAddr_wb; e_wd = RegWriteData_wb;
      end else if (mq.size() > 0 && mq[0].live) begin
        e_we = 1'b1; e_wa = mq[0].a; e_wd = mq[0].d;
      end
    end
  endtask

  // Reference: what the clock edge does to the queue and the starvation count.
  task automatic model_step();
    logic pw, was_empty, head_written, any_live, accepted;
    ent_t e;
    if (rst) begin
      mq.delete();
      m_starve = 0;
      return;
    end
    pw           = RegWrite_wb && (RegWriteAddr_wb != 5'd0);
    was_empty    = (mq.size() == 0);
    head_written = !pw && !was_empty && mq[0].live;
    accepted     = mdu_valid && (mq.size() < DEPTH);
    any_live     = 1'b0;
    foreach (mq[i]) if (mq[i].live) any_live = 1'b1;
    if (pw) foreach (mq[i]) if (mq[i].a == RegWriteAddr_wb) mq[i].live = 1'b0;
    if (!pw && !was_empty) void'(mq.pop_front());
    if (accepted && mdu_addr != 5'd0) begin
      e.a = mdu_addr; e.d = mdu_data; e.live = 1'b1;
      mq.push_back(e);
    end
    if (was_empty || head_written) m_starve = 0;
    else if (pw && any_live && m_starve < LIMIT) m_starve = m_starve + 1;
  endtask

  initial begin
    logic        e_we, e_rdy, e_stall;
    logic [4:0]  e_wa;
    logic [31:0] e_wd, e_mask;
    logic        prev_stall;

    drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    //          r  we  wa     wd            mv  ma     md            e_we e_wa   e_wd          rdy st  mask
    // reset with both requesters active
    tbl.push_back(mk(1, 1, 5'd9,  32'h1,        1, 5'd3,  32'h5,        0, 5'd0,  32'h0,        0, 0, 32'h0));
    tbl.push_back(mk(1, 1, 5'd9,  32'h1,        1, 5'd3,  32'h5,        0, 5'd0,  32'h0,        0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 0, 32'h0));
    // idle slot drain
    tbl.push_back(mk(0, 0, 5'd0,  32'h0,        1, 5'd8,  32'hDEADBEEF, 0, 5'd0,  32'h0,        1, 0, 32'h0));
    tbl.push_back(mk(0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 5'd8,  32'hDEADBEEF, 1, 0, 32'h100));
    tbl.push_back(mk(0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 0, 32'h0));
    // priority, full queue (push attempt while full is refused), starvation with two entries
    tbl.push_back(mk(0, 1, 5'd9,  32'h99,       1, 5'd3,  32'h33,       1, 5'd9,  32'h99,       1, 0, 32'h0));
    tbl.push_back(mk(0, 1, 5'd9,  32'h99,       1, 5'd4,  32'h44,       1, 5'd9,  32'h99,       1, 0, 32'h8));
    tbl.push_back(mk(0, 1, 5'd9,  32'h99,       1, 5'd11, 32'hBB,       1, 5'd9,  32'h99,       0, 0, 32'h18));
    tbl.push_back(mk(0, 1, 5'd9,  32'h99,       0, 5'd0,  32'h0,        1, 5'd9,  32'h99,       0, 0, 32'h18));
    tbl.push_back(mk(0, 1, 5'd9,  32'h99,       0, 5'd0,  32'h0,        1, 5'd9,  32'h99,       0, 0, 32'h18));
    tbl.push_back(mk(0, 1, 5'd9,  32'h99,       0, 5'd0,  32'h0,        1, 5'd9,  32'h99,       0, 1, 32'h18));
    tbl.push_back(mk(0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 5'd3,  32'h33,       0, 1, 32'h18));
    tbl.push_back(mk(0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 5'd4,  32'h44,       1, 0, 32'h10));
    tbl.push_back(mk(0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 0, 32'h0));
    // starvation with one entry: pw for 4 cycles, stall on the 5th, bubble drains it
    tbl.push_back(mk(0, 0, 5'd0,  32'h0,        1, 5'd7,  32'h77,       0, 5'd0,  32'h0,        1, 0, 32'h0));
    tbl.push_back(mk(0, 1, 5'd10, 32'hA0,       0, 5'd0,  32'h0,        1, 5'd10, 32'hA0,       1, 0, 32'h80));
    tbl.push_back(mk(0, 1, 5'd10, 32'hA0,       0, 5'd0,  32'h0,        1, 5'd10, 32'hA0,       1, 0, 32'h80));
    tbl.push_back(mk(0, 1, 5'd10, 32'hA0,       0, 5'd0,  32'h0,        1, 5'd10, 32'hA0,       1, 0, 32'h80));
    tbl.push_back(mk(0, 1, 5'd10, 32'hA0,       0, 5'd0,  32'h0,        1, 5'd10, 32'hA0,       1, 0, 32'h80));
    tbl.push_back(mk(0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 5'd7,  32'h77,       1, 1, 32'h80));
    tbl.push_back(mk(0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 0, 32'h0));
    // WAW kill: queued r5 is superseded, killed head leaves without a write
    tbl.push_back(mk(0, 0, 5'd0,  32'h0,        1, 5'd5,  32'h11,       0, 5'd0,  32'h0,        1, 0, 32'h0));
    tbl.push_back(mk(0, 1, 5'd5,  32'h22,       0, 5'd0,  32'h0,        1, 5'd5,  32'h22,       1, 0, 32'h20));
    tbl.push_back(mk(0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 0, 32'h0));
    tbl.push_back(mk(0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 0, 32'h0));
    // push in the same cycle as a matching pw survives
    tbl.push_back(mk(0, 1, 5'd5,  32'h55,       1, 5'd5,  32'h66,       1, 5'd5,  32'h55,       1, 0, 32'h0));
    tbl.push_back(mk(0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 5'd5,  32'h66,       1, 0, 32'h20));
    // $0 handling on both sides
    tbl.push_back(mk(0, 0, 5'd0,  32'h0,        1, 5'd12, 32'hC,        0, 5'd0,  32'h0,        1, 0, 32'h0));
    tbl.push_back(mk(0, 1, 5'd0,  32'hFF,       0, 5'd0,  32'h0,        1, 5'd12, 32'hC,        1, 0, 32'h1000));
    tbl.push_back(mk(0, 0, 5'd0,  32'h0,        1, 5'd0,  32'hAB,       0, 5'd0,  32'h0,        1, 0, 32'h0));
    tbl.push_back(mk(0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 0, 32'h0));
    // reset mid-operation discards queued results
    tbl.push_back(mk(0, 0, 5'd0,  32'h0,        1, 5'd2,  32'h2,        0, 5'd0,  32'h0,        1, 0, 32'h0));
    tbl.push_back(mk(0, 1, 5'd9,  32'h9,        1, 5'd1,  32'h1,        1, 5'd9,  32'h9,        1, 0, 32'h4));
    tbl.push_back(mk(1, 0, 5'd0,  32'h0,        1, 5'd6,  32'h6,        0, 5'd0,  32'h0,        0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 0, 32'h0));
    tbl.push_back(mk(0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 0, 32'h0));

    foreach (tbl[k]) begin
      @(posedge clk); #1;
      drive(tbl[k].r, tbl[k].we, tbl[k].wa, tbl[k].wd, tbl[k].mv, tbl[k].ma, tbl[k].md);
      @(negedge clk);
      chk($sformatf("vec%0d rf_we", k),        32'(rf_we),        32'(tbl[k].e_we));
      chk($sformatf("vec%0d rf_waddr", k),     32'(rf_waddr),     32'(tbl[k].e_wa));
      chk($sformatf("vec%0d rf_wdata", k),     rf_wdata,          tbl[k].e_wd);
      chk($sformatf("vec%0d mdu_ready", k),    32'(mdu_ready),    32'(tbl[k].e_rdy));
      chk($sformatf("vec%0d stall_req_wb", k), 32'(stall_req_wb), 32'(tbl[k].e_stall));
      chk($sformatf("vec%0d pending_mask", k), pending_mask,      tbl[k].e_mask);
    end

    // Random traffic; narrow address range to provoke WAW kills and $0 cases.
    mq.delete();
    m_starve   = 0;
    prev_stall = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      logic r, we, mv;
      r  = (c == 0) || ($urandom_range(0, 99) == 0);
      // Emulate the hazard unit bubbling WB after a freeze request most of the time.
      we = (prev_stall && $urandom_range(0, 3) != 0) ? 1'b0 : 1'($urandom_range(0, 1));
      mv = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
      drive(r, we, 5'($urandom_range(0, 7)), $urandom(), mv, 5'($urandom_range(0, 7)), $urandom());
      @(negedge clk);
      model_out(e_we, e_wa, e_wd, e_rdy, e_stall, e_mask);
      chk($sformatf("rnd%0d rf_we", c),        32'(rf_we),        32'(e_we));
      chk($sformatf("rnd%0d rf_waddr", c),     32'(rf_waddr),     32'(e_wa));
      chk($sformatf("rnd%0d rf_wdata", c),     rf_wdata,          e_wd);
      chk($sformatf("rnd%0d mdu_ready", c),    32'(mdu_ready),    32'(e_rdy));
      chk($sformatf("rnd%0d stall_req_wb", c), 32'(stall_req_wb), 32'(e_stall));
      chk($sformatf("rnd%0d pending_mask", c), pending_mask,      e_mask);
      prev_stall = e_stall;
      model_step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_wb_port_arbiter.md
Name: cpu_wb_port_arbiter

Overview:
- Shares the single register-file write port between the pipeline WB stage and the multi-cycle multiply/divide unit (MDU).
- The WB stage always has priority. MDU results wait in a small pending queue and are written in idle WB slots.
- A starvation counter requests a one-cycle pipeline freeze so a queued MDU result can drain.
- Exports a busy mask of pending destination registers to the hazard unit.

Parameters:
- DEPTH, 2, number of pending MDU result entries (2..4).
- STARVE_LIMIT, 4, consecutive cycles a non-empty queue is denied the port before stall_req_wb asserts (1..15).

Ports:
- clk  in  1  system clock, all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- RegWrite_wb  in  1  WB stage write enable.
- RegWriteAddr_wb  in  5  WB stage destination register.
- RegWriteData_wb  in  32  WB stage write data (output of the WB result mux).
- mdu_valid  in  1  MDU result available this cycle.
- mdu_addr  in  5  MDU destination register.
- mdu_data  in  32  MDU result.
- mdu_ready  out  1  queue can accept an MDU result this cycle.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  5  register-file write address.
- rf_wdata  out  32  register-file write data.
- stall_req_wb  out  1  freeze request to the hazard unit.
- pending_mask  out  32  bit n set means register n has a queued MDU write.

Behaviour:
- Reset (rst=1 at a clock edge):
  - queue emptied, starvation counter cleared.
  - While rst is high, rf_we=0, mdu_ready=0, stall_req_wb=0, pending_mask=0.
  - Reset mid-operation discards all queued results without writing them.
- Pipeline write valid: pw = RegWrite_wb && RegWriteAddr_wb != 0. Writes to $0 are treated as no write.
- Port select (combinational, same cycle):
  - If pw: rf_we=1, rf_waddr/rf_wdata come from the WB inputs.
  - Else if the queue is non-empty: rf_we=1 and the head entry is written and popped at the clock edge.
  - Else rf_we=0, rf_waddr=0, rf_wdata=0.
- Queue:
  - In-order FIFO of {addr, data}. mdu_ready = !full, computed from registered state.
  - Push occurs when mdu_valid && mdu_ready. A push while full is impossible by construction.
  - mdu_valid with mdu_addr=0 is accepted (mdu_ready honoured) but not enqueued.
  - Push and pop in the same cycle are both performed; occupancy is unchanged.
  - An entry pushed in cycle N is eligible for the port in cycle N+1 at the earliest (latency 1 when the port is idle).
  - Pointers wrap modulo DEPTH.
- WAW kill:
  - When pw, every valid queued entry whose addr equals RegWriteAddr_wb is invalidated at the clock edge (the younger pipeline value wins).
  - Invalid entries still occupy a slot. When an invalid entry reaches the head it is popped without asserting rf_we; this consumes the slot if the port is otherwise idle.
  - An entry pushed in the same cycle as a matching pw is not killed.
- pending_mask: OR of one-hot(addr) over valid queued entries, registered-state based. Killed and popped entries clear at the edge.
- Starvation counter:
  - Increments each cycle in which the queue holds a valid entry and pw=1.
  - Clears on any cycle the queue is empty or the head is written.
  - Saturates at STARVE_LIMIT.
  - stall_req_wb = (counter == STARVE_LIMIT), registered.
  - The hazard unit responds by bubbling WB, so RegWrite_wb=0 in the following cycle. The head is then written, the counter clears, and stall_req_wb drops one cycle later.

Test Plan:
- Reset: apply rst for 2 cycles with mdu_valid=1 and RegWrite_wb=1 -> rf_we=0, mdu_ready=0, pending_mask=0 throughout. After release, mdu_ready=1.
- Idle slot drain: mdu_valid=1, mdu_addr=8, mdu_data=0xDEADBEEF, RegWrite_wb=0 -> next cycle rf_we=1, rf_waddr=8, rf_wdata=0xDEADBEEF; pending_mask bit 8 set for exactly one cycle.
- Priority and full: push addr 3, then addr 4, with RegWrite_wb=1 (addr 9) every cycle -> rf_waddr=9 each cycle, mdu_ready=0 after the second push, pending_mask=0x18.
- Starvation (STARVE_LIMIT=4): one queued entry, pw held for 4 cycles -> stall_req_wb=1 on cycle 5. Drop pw the next cycle -> queued entry written, stall_req_wb=0 the cycle after.
- WAW kill: queue addr 5 (data 0x11) while a pw to addr 5 (data 0x22) is active -> entry invalidated, pending_mask bit 5 clears, register 5 never written with 0x11, slot freed on the next idle cycle.
- $0 handling: RegWrite_wb=1 with addr 0 and one entry queued -> queued entry is written that cycle. mdu_valid with addr 0 -> nothing queued, rf_we stays 0.
